param_ram: RTL and testbench

Parametrised single-port synchronous RAM for the memory subsystem. It succeeds the fixed 32x8 RAM.
- Width, depth and reset-time fill value are generic.
- Access uses a valid/ready request handshake with a registered read path and read-valid strobe.
- A hardware clear sequencer sweeps the whole array after reset or on command.
- A per-bit output selects one bit of the last read word.

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_core.sv | 32 +++
 rtl/param_ram.sv | 153 +++++++++++++++
 tb/tb_param_ram.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared constants for the parametrised RAM: state and opcode encodings.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 8;
    localparam int c_DEFAULT_DEPTH      = 32;

    localparam logic [0:0] c_STATE_INIT = 1'b0;
    localparam logic [0:0] c_STATE_IDLE = 1'b1;

    localparam logic c_OP_WRITE = 1'b1;
    localparam logic c_OP_READ  = 1'b0;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_core.sv
`default_nettype none
// ============================================================================
// Module   : ram_core
// Purpose  : Bare storage array, one write port and one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module ram_core
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = c_DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata_registered
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata_registered <= r_mem[raddr];
    end

endmodule : ram_core
`default_nettype wire

// File: rtl/param_ram.sv
`default_nettype none
// ============================================================================
// Module   : param_ram
// Purpose  : Single-port RAM with valid/ready access, clear sweep and bit select.
// Revision : 1.0 - initial release
// ============================================================================
module param_ram
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int                    DEPTH      = c_DEFAULT_DEPTH,
    parameter int                    ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          write1_read0,
    input  logic [ADDR_WIDTH-1:0]         address,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic [$clog2(DATA_WIDTH)-1:0] bit_sel,
    input  logic                          clear,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_out_valid,
    output logic                          data_out_by_bit,
    output logic                          addr_error,
    output logic                          init_done
);

    localparam logic [ADDR_WIDTH:0]   c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]                    r_state;
    logic [0:0]                    w_state_next;
    logic [ADDR_WIDTH-1:0]         r_sweep_ptr;

    logic                          w_accept;
    logic                          w_in_range;
    logic                          w_rd_accept;
    logic                          w_wr_accept;

    logic                          w_we;
    logic [ADDR_WIDTH-1:0]         w_waddr;
    logic [DATA_WIDTH-1:0]         w_wdata;
    logic [ADDR_WIDTH-1:0]         w_raddr;
    logic [DATA_WIDTH-1:0]         w_rdata;

    logic                          r_rd_valid;
    logic                          r_rd_oor;
    logic                          r_addr_error;
    logic [DATA_WIDTH-1:0]         r_data_hold;
    logic [$clog2(DATA_WIDTH)-1:0] r_bit_sel;
    logic [DATA_WIDTH-1:0]         w_data_out;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_STATE_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_STATE_INIT: if (r_sweep_ptr == c_LAST_ADDR) w_state_next = c_STATE_IDLE;
            c_STATE_IDLE: if (clear)                      w_state_next = c_STATE_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // clear wins over a same-cycle request by withdrawing ready.
    always_comb begin
        init_done = 1'b0;
        req_ready = 1'b0;
        case (r_state)
            c_STATE_INIT: begin
                init_done = 1'b0;
                req_ready = 1'b0;
            end
            c_STATE_IDLE: begin
                init_done = 1'b1;
                req_ready = !clear;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sweep_ptr <= '0;
        end else if (r_state == c_STATE_INIT) begin
            r_sweep_ptr <= (r_sweep_ptr == c_LAST_ADDR) ? '0 : r_sweep_ptr + ADDR_WIDTH'(1);
        end else if (clear) begin
            r_sweep_ptr <= '0;
        end
    end

    assign w_accept    = req_valid && req_ready;
    assign w_in_range  = {1'b0, address} < c_DEPTH_EXT;
    assign w_rd_accept = w_accept && (write1_read0 == c_OP_READ);
    assign w_wr_accept = w_accept && (write1_read0 == c_OP_WRITE) && w_in_range;

    // Write port is owned by the sweep during INIT, by requests otherwise.
    assign w_we    = (r_state == c_STATE_INIT) || w_wr_accept;
    assign w_waddr = (r_state == c_STATE_INIT) ? r_sweep_ptr : address;
    assign w_wdata = (r_state == c_STATE_INIT) ? INIT_VALUE  : data_in;
    assign w_raddr = w_in_range ? address : '0;

    ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clock            (clock),
        .we               (w_we),
        .waddr            (w_waddr),
        .wdata            (w_wdata),
        .raddr            (w_raddr),
        .rdata_registered (w_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_valid   <= 1'b0;
            r_rd_oor     <= 1'b0;
            r_addr_error <= 1'b0;
            r_data_hold  <= '0;
            r_bit_sel    <= '0;
        end else begin
            r_rd_valid   <= w_rd_accept;
            r_rd_oor     <= w_rd_accept && !w_in_range;
            r_addr_error <= w_accept && !w_in_range;
            r_data_hold  <= w_data_out;
            if (w_rd_accept) begin
                r_bit_sel <= bit_sel;
            end
        end
    end

    // The core output is only meaningful in the cycle after a read; otherwise
    // the last presented word is replayed from the hold register.
    assign w_data_out = r_rd_valid ? (r_rd_oor ? '0 : w_rdata) : r_data_hold;

    assign data_out        = w_data_out;
    assign data_out_valid  = r_rd_valid;
    assign data_out_by_bit = w_data_out[r_bit_sel];
    assign addr_error      = r_addr_error;

endmodule : param_ram
`default_nettype wire

// File: tb/tb_param_ram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_param_ram
// Purpose  : Randomised self-checking bench for param_ram (DEPTH 32 and 20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_ram;

    localparam int DW  = 8;
    localparam int D   = 32;
    localparam int AW  = 5;
    localparam int BW  = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // DEPTH = 32 instance
    logic          reset, req_valid, write1_read0, clear;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [BW-1:0] bit_sel;
    logic          req_ready, data_out_valid, data_out_by_bit, addr_error, init_done;
    logic [DW-1:0] data_out;

    // DEPTH = 20 instance
    logic          rst_b, valid_b, wr_b, clear_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
    logic [BW-1:0] sel_b;
    logic          ready_b, dvalid_b, bybit_b, err_b, done_b;
    logic [DW-1:0] dout_b;

    param_ram u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .write1_read0(write1_read0), .address(address), .data_in(data_in),
        .bit_sel(bit_sel), .clear(clear), .data_out(data_out),
        .data_out_valid(data_out_valid), .data_out_by_bit(data_out_by_bit),
        .addr_error(addr_error), .init_done(init_done)
    );

    param_ram #(.DEPTH(20), .INIT_VALUE(8'h5A)) u_dut20 (
        .clock(clock), .reset(rst_b), .req_valid(valid_b), .req_ready(ready_b),
        .write1_read0(wr_b), .address(addr_b), .data_in(din_b),
        .bit_sel(sel_b), .clear(clear_b), .data_out(dout_b),
        .data_out_valid(dvalid_b), .data_out_by_bit(bybit_b),
        .addr_error(err_b), .init_done(done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: array contents plus the word and bit index last presented.
    logic [DW-1:0] exp_mem [D];
    logic [DW-1:0] exp_dout;
    logic [BW-1:0] exp_bsel;
    logic          exp_valid;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) exp_mem[i] = '0;
    endtask

    task automatic drive(input logic v, input logic w, input int a,
                         input logic [DW-1:0] d, input int b);
        req_valid    = v;
        write1_read0 = w;
        address      = AW'(a);
        data_in      = d;
        bit_sel      = BW'(b);
        tick();
        req_valid = 1'b0;
        exp_valid = v && !w;
        if (v && !w) begin
            exp_dout = exp_mem[a];
            exp_bsel = BW'(b);
        end
        if (v && w) exp_mem[a] = d;
    endtask

    task automatic drive_b(input logic v, input logic w, input int a, input logic [DW-1:0] d);
        valid_b = v;
        wr_b    = w;
        addr_b  = AW'(a);
        din_b   = d;
        tick();
        valid_b = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({data_out, data_out_valid, data_out_by_bit, addr_error, init_done, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%h v=%b bit=%b err=%b done=%b rdy=%b required all 0",
                     data_out, data_out_valid, data_out_by_bit, addr_error, init_done, req_ready);
        end
        reset = 1'b0;
        cnt = 0;
        while (init_done !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != 32) begin
            n_fail++;
            $display("FAIL reset_sweep_len: got %0d cycles required 32", cnt);
        end
        model_clear();
        exp_dout = '0;
        exp_bsel = '0;
    endtask

    task automatic test_zero_read();
        for (int i = 0; i < D; i++) begin
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_read_ready addr=%0d: got %b required 1", i, req_ready);
            end
            drive(1'b1, 1'b0, i, '0, i % 8);
            n_checks++;
            if (data_out_valid !== 1'b1 || data_out !== exp_dout) begin
                n_fail++;
                $display("FAIL zero_read addr=%0d: got v=%b d=%h required v=1 d=%h", i, data_out_valid, data_out, exp_dout);
            end
        end
        drive(1'b0, 1'b0, 0, '0, 0);
        n_checks++;
        if (data_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_read_strobe_end: got %b required 0", data_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < D; j++) begin
            drive(1'b1, 1'b1, j, DW'(j + 1), 0);
            n_checks++;
            if ({data_out_valid, addr_error} !== 2'b00) begin
                n_fail++;
                $display("FAIL fill_write addr=%0d: got v=%b err=%b required 0 0", j, data_out_valid, addr_error);
            end
        end
        for (int j = 0; j < D; j++) begin
            drive(1'b1, 1'b0, j, '0, 0);
            n_checks++;
            if (data_out_valid !== 1'b1 || data_out !== exp_dout) begin
                n_fail++;
                $display("FAIL fill_read addr=%0d: got v=%b d=%h required v=1 d=%h", j, data_out_valid, data_out, exp_dout);
            end
        end
    endtask

    task automatic test_bit_select();
        drive(1'b1, 1'b1, 5, 8'hA5, 0);
        drive(1'b1, 1'b0, 5, '0, 0);
        n_checks++;
        if (data_out !== 8'hA5 || data_out_by_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL bitsel0: got d=%h bit=%b required d=a5 bit=1", data_out, data_out_by_bit);
        end
        drive(1'b1, 1'b0, 5, '0, 1);
        n_checks++;
        if (data_out !== 8'hA5 || data_out_by_bit !== 1'b0) begin
            n_fail++;
            $display("FAIL bitsel1: got d=%h bit=%b required d=a5 bit=0", data_out, data_out_by_bit);
        end
        drive(1'b1, 1'b1, 5, 8'h3C, 2);
        n_checks++;
        if (data_out !== 8'hA5 || data_out_by_bit !== 1'b0 || data_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_on_write: got d=%h bit=%b v=%b required d=a5 bit=0 v=0",
                     data_out, data_out_by_bit, data_out_valid);
        end
        drive(1'b1, 1'b0, 5, '0, 2);
        n_checks++;
        if (data_out !== exp_dout || data_out_by_bit !== exp_dout[exp_bsel]) begin
            n_fail++;
            $display("FAIL raw_read: got d=%h bit=%b required d=%h bit=%b",
                     data_out, data_out_by_bit, exp_dout, exp_dout[exp_bsel]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int a;
            a = ($urandom % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, D - 1));
            drive(($urandom % 4) != 0, $urandom % 2 == 1, a, DW'($urandom), int'($urandom_range(0, 7)));
            n_checks++;
            if (data_out_valid !== exp_valid || data_out !== exp_dout ||
                data_out_by_bit !== exp_dout[exp_bsel]) begin
                n_fail++;
                $display("FAIL random cycle=%0d: got v=%b d=%h bit=%b required v=%b d=%h bit=%b", n,
                         data_out_valid, data_out, data_out_by_bit, exp_valid, exp_dout, exp_dout[exp_bsel]);
            end
        end
    endtask

    task automatic test_clear();
        int cnt;
        for (int j = 0; j < D; j++) drive(1'b1, 1'b1, j, DW'(j + 1), 0);
        clear = 1'b1;
        req_valid = 1'b1;
        write1_read0 = 1'b0;
        address = AW'(3);
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ready: got %b required 0", req_ready);
        end
        tick();
        clear = 1'b0;
        req_valid = 1'b0;
        n_checks++;
        if (data_out_valid !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_reject: got v=%b done=%b required 0 0", data_out_valid, init_done);
        end
        cnt = 0;
        while (init_done !== 1'b1 && cnt < 100) begin
            clear = (cnt == 10);
            tick();
            clear = 1'b0;
            cnt++;
        end
        n_checks++;
        if (cnt != 32) begin
            n_fail++;
            $display("FAIL clear_sweep_len: got %0d cycles required 32", cnt);
        end
        model_clear();
        for (int j = 0; j < D; j++) begin
            drive(1'b1, 1'b0, j, '0, 0);
            n_checks++;
            if (data_out_valid !== 1'b1 || data_out !== exp_dout) begin
                n_fail++;
                $display("FAIL clear_read addr=%0d: got v=%b d=%h required v=1 d=%h", j, data_out_valid, data_out, exp_dout);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        drive(1'b1, 1'b1, 1, 8'hC3, 0);
        drive(1'b1, 1'b0, 1, '0, 7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (data_out !== 8'hC3 || data_out_by_bit !== 1'b1 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_hold: got d=%h bit=%b done=%b required d=c3 bit=1 done=0",
                     data_out, data_out_by_bit, init_done);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({data_out, data_out_valid, data_out_by_bit, addr_error, init_done, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got d=%h v=%b bit=%b err=%b done=%b rdy=%b required all 0",
                     data_out, data_out_valid, data_out_by_bit, addr_error, init_done, req_ready);
        end
        repeat (3) tick();
        reset = 1'b0;
        cnt = 0;
        while (init_done !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != 32) begin
            n_fail++;
            $display("FAIL restart_sweep_len: got %0d cycles required 32", cnt);
        end
        model_clear();
        exp_dout = '0;
        exp_bsel = '0;
        drive(1'b1, 1'b0, 1, '0, 0);
        n_checks++;
        if (data_out !== exp_dout || data_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_read: got d=%h v=%b required d=%h v=1", data_out, data_out_valid, exp_dout);
        end
    endtask

    task automatic test_out_of_range();
        int cnt;
        rst_b = 1'b0;
        cnt = 0;
        while (done_b !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != 20 || ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL d20_sweep: got %0d cycles rdy=%b required 20 rdy=1", cnt, ready_b);
        end
        drive_b(1'b1, 1'b0, 5, '0);
        n_checks++;
        if (dout_b !== 8'h5A || dvalid_b !== 1'b1 || err_b !== 1'b0) begin
            n_fail++;
            $display("FAIL d20_init_value: got d=%h v=%b err=%b required d=5a v=1 err=0", dout_b, dvalid_b, err_b);
        end
        drive_b(1'b1, 1'b1, 5, 8'h11);
        drive_b(1'b1, 1'b1, 25, 8'h33);
        n_checks++;
        if (err_b !== 1'b1 || dvalid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL d20_oor_write: got err=%b v=%b required err=1 v=0", err_b, dvalid_b);
        end
        drive_b(1'b0, 1'b0, 0, '0);
        n_checks++;
        if (err_b !== 1'b0) begin
            n_fail++;
            $display("FAIL d20_err_pulse: got %b required 0", err_b);
        end
        drive_b(1'b1, 1'b0, 5, '0);
        n_checks++;
        if (dout_b !== 8'h11 || bybit_b !== 1'b1 || err_b !== 1'b0) begin
            n_fail++;
            $display("FAIL d20_mem5: got d=%h bit=%b err=%b required d=11 bit=1 err=0", dout_b, bybit_b, err_b);
        end
        drive_b(1'b1, 1'b0, 19, '0);
        n_checks++;
        if (dout_b !== 8'h5A || err_b !== 1'b0) begin
            n_fail++;
            $display("FAIL d20_last_addr: got d=%h err=%b required d=5a err=0", dout_b, err_b);
        end
        drive_b(1'b1, 1'b0, 25, '0);
        n_checks++;
        if (dout_b !== 8'h00 || dvalid_b !== 1'b1 || err_b !== 1'b1) begin
            n_fail++;
            $display("FAIL d20_oor_read25: got d=%h v=%b err=%b required d=00 v=1 err=1", dout_b, dvalid_b, err_b);
        end
        drive_b(1'b1, 1'b0, 19, '0);
        drive_b(1'b1, 1'b0, 20, '0);
        n_checks++;
        if (dout_b !== 8'h00 || dvalid_b !== 1'b1 || err_b !== 1'b1) begin
            n_fail++;
            $display("FAIL d20_oor_read20: got d=%h v=%b err=%b required d=00 v=1 err=1", dout_b, dvalid_b, err_b);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; write1_read0 = 1'b0; clear = 1'b0;
        address = '0; data_in = '0; bit_sel = '0;
        rst_b = 1'b1; valid_b = 1'b0; wr_b = 1'b0; clear_b = 1'b0;
        addr_b = '0; din_b = '0; sel_b = '0;
        exp_dout = '0; exp_bsel = '0; exp_valid = 1'b0;
        model_clear();

        test_reset();
        test_zero_read();
        test_back_to_back();
        test_bit_select();
        test_random();
        test_clear();
        test_reset_mid_sweep();
        test_out_of_range();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_param_ram
`default_nettype wire
